// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter steering the owner's data bit to a registered y
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       req,
    input  logic [3:0]       din,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_vld,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             y
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n, owner_n;
    logic [CNT_W-1:0] hold_n;
    logic             win_found;
    logic [1:0]       win_id;
    logic [1:0]       idx;
    logic             take_winner;

    // Scan from ptr upward; iterating offsets high-to-low lets the nearest one win.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        idx       = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = gnt_id;
        hold_n      = hold_cnt;
        ptr_n       = ptr;
        take_winner = 1'b0;
        case (state)
            IDLE: begin
                hold_n = '0;
                if (en && win_found) take_winner = 1'b1;
            end
            GRANT: begin
                if (!en) begin
                    state_n = IDLE;
                    hold_n  = '0;
                end else if (!req[gnt_id]) begin
                    if (win_found) begin
                        take_winner = 1'b1;
                    end else begin
                        state_n = IDLE;
                        hold_n  = '0;
                    end
                end else if (hold_cnt == MAX_C && (req & ~gnt) != 4'b0000) begin
                    // ptr already points past the owner, so the winner is someone else
                    take_winner = 1'b1;
                end else if (hold_cnt != MAX_C) begin
                    hold_n = hold_cnt + ONE_C;
                end
            end
            default: state_n = IDLE;
        endcase
        if (take_winner) begin
            state_n = GRANT;
            owner_n = win_id;
            hold_n  = ONE_C;
            ptr_n   = win_id + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            gnt_id   <= 2'd0;
            hold_cnt <= '0;
            ptr      <= 2'd0;
            y        <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= (state_n == GRANT) ? (4'b0001 << owner_n) : 4'b0000;
            gnt_id   <= owner_n;
            hold_cnt <= hold_n;
            ptr      <= ptr_n;
            if (state == GRANT) y <= din[gnt_id];
        end
    end

    assign gnt_vld = (state == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - randomized scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset, en;
    logic [3:0]       req, din, gnt;
    logic [1:0]       gnt_id;
    logic             gnt_vld;
    logic [CNT_W-1:0] hold_cnt;
    logic             y;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .din(din),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .hold_cnt(hold_cnt), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic [3:0] hold;
        logic       y;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model: owner index (-1 = idle), hold count, pointer, output bit
    int   m_owner = -1;
    int   m_cnt   = 0;
    int   m_ptr   = 0;
    logic m_y     = 1'b0;

    function automatic void model_grant(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (r[c]) begin
                m_owner = c;
                m_cnt   = 1;
                m_ptr   = (c + 1) % 4;
                return;
            end
        end
    endfunction

    function automatic void model_idle();
        m_owner = -1;
        m_cnt   = 0;
    endfunction

    task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] d);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; req = rq; din = d;
        if (r) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0; m_y = 1'b0;
        end else if (m_owner < 0) begin
            if (e && rq != 4'b0000) model_grant(rq);
        end else begin
            m_y = d[m_owner];
            if (!e) model_idle();
            else if (!rq[m_owner]) begin
                if (rq != 4'b0000) model_grant(rq);
                else model_idle();
            end else if (m_cnt == MAX_HOLD && (rq & ~(4'b0001 << m_owner)) != 4'b0000)
                model_grant(rq);
            else if (m_cnt < MAX_HOLD)
                m_cnt = m_cnt + 1;
        end
        x.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        x.id   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        x.vld  = (m_owner >= 0);
        x.hold = 4'(m_cnt);
        x.y    = m_y;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt", 8'(gnt), 8'(e.gnt));
                chk("gnt_vld", 8'(gnt_vld), 8'(e.vld));
                chk("hold_cnt", 8'(hold_cnt), 8'(e.hold));
                chk("y", 8'(y), 8'(e.y));
                if (e.vld) chk("gnt_id", 8'(gnt_id), 8'(e.id));
            end
        end
    end

    initial begin : stim
        logic [3:0] rq;
        reset = 1'b1; en = 1'b0; req = 4'b0000; din = 4'b0000;
        // reset dominance then first grant to requester 0
        repeat (2) step(1'b1, 1'b1, 4'b1111, 4'($urandom));
        repeat (3) step(1'b0, 1'b1, 4'b1111, 4'($urandom));
        // single owner, hold count saturates
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        repeat (22) step(1'b0, 1'b1, 4'b0100, 4'b0100);
        // full contention rotation
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        repeat (40) step(1'b0, 1'b1, 4'b1111, 4'($urandom));
        // release handoff without bubble, then drop all
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        repeat (3) step(1'b0, 1'b1, 4'b0010, 4'($urandom));
        repeat (3) step(1'b0, 1'b1, 4'b1000, 4'($urandom));
        repeat (3) step(1'b0, 1'b1, 4'b0000, 4'($urandom));
        // enable drop mid-grant
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        repeat (4) step(1'b0, 1'b1, 4'b1111, 4'($urandom));
        repeat (3) step(1'b0, 1'b0, 4'b1111, 4'($urandom));
        repeat (4) step(1'b0, 1'b1, 4'b1111, 4'($urandom));
        // reset while requester 2 holds with hold_cnt 5
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        repeat (5) step(1'b0, 1'b1, 4'b0100, 4'($urandom));
        step(1'b1, 1'b1, 4'b1111, 4'($urandom));
        repeat (3) step(1'b0, 1'b1, 4'b1111, 4'($urandom));
        // randomized traffic with persistent requests
        rq = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) rq = 4'($urandom);
            step(($urandom_range(199) == 0), ($urandom_range(15) != 0), rq, 4'($urandom));
        end
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
